softmax_rowstat_engine: RTL



---
 rtl/softmax_rowstat_engine.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/softmax_rowstat_engine.sv
// softmax_rowstat_engine
//   Reduces an M-row x S-token score stream to one statistic per row.
//   LANES tokens arrive per beat. Three modes: INDEX (row+token checksum
//   computed internally with no input consumed), SUM (row sum of scores)
//   and MAX (signed row max). Each row result is offered on a valid/ready
//   port, and the accepted results are accumulated into a job checksum.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start/mode/m_rows/s_tokens  job launch, sampled in IDLE only
//   in_valid/in_ready/in_data   score beats, lane k = token beat*LANES+k
//   row_valid/row_ready/row_idx/row_result  per-row result handshake
//   busy/done/err/checksum_out  job status and final checksum
module softmax_rowstat_engine #(
   parameter int DATA_W = 16,
   parameter int LANES  = 4,
   parameter int DIM_W  = 16,
   parameter int ACC_W  = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              mode,
   input  logic [DIM_W-1:0]        m_rows,
   input  logic [DIM_W-1:0]        s_tokens,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    row_valid,
   input  logic                    row_ready,
   output logic [DIM_W-1:0]        row_idx,
   output logic [ACC_W-1:0]        row_result,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [ACC_W-1:0]        checksum_out
);

   localparam logic [1:0] M_INDEX = 2'd0;
   localparam logic [1:0] M_SUM   = 2'd1;
   localparam logic [1:0] M_MAX   = 2'd2;
   // Token base width leaves headroom so base+LANES never wraps past s_tokens.
   localparam int TW = DIM_W + $clog2(LANES) + 2;

   typedef enum logic [1:0] {IDLE, RUN, ROW_OUT, DONE} state_t;

   state_t             state;
   logic [1:0]         mode_r;
   logic [DIM_W-1:0]   m_r;
   logic [DIM_W-1:0]   s_r;
   logic [DIM_W:0]     row;
   logic [TW-1:0]      tok;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_nxt;
   logic [ACC_W-1:0]   checksum;
   logic [LANES-1:0][ACC_W-1:0] lane_ext;
   logic               beat_go;
   logic               last_beat;
   logic               last_row;

   assign checksum_out = checksum;

   function automatic logic [ACC_W-1:0] acc_init(input logic [1:0] md);
      // MAX starts at the most negative DATA_W value, sign-extended.
      if (md == M_MAX)
         acc_init = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
      else
         acc_init = '0;
   endfunction

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign lane_ext[k] = {{(ACC_W-DATA_W){in_data[k*DATA_W+DATA_W-1]}},
                            in_data[k*DATA_W +: DATA_W]};
   end

   // INDEX advances one internal beat per cycle; SUM/MAX need a handshake.
   assign beat_go   = (state == RUN) && ((mode_r == M_INDEX) || (in_valid && in_ready));
   assign last_beat = (tok + TW'(LANES)) >= TW'(s_r);
   assign last_row  = (row + 1'b1) >= {1'b0, m_r};

   always_comb begin
      acc_nxt = acc;
      for (int k = 0; k < LANES; k++) begin
         // Lanes past the end of the row in the final beat are padding.
         if ((tok + TW'(k)) < TW'(s_r)) begin
            case (mode_r)
               M_INDEX: acc_nxt = acc_nxt + ACC_W'(row) + ACC_W'(tok + TW'(k));
               M_SUM:   acc_nxt = acc_nxt + lane_ext[k];
               M_MAX:   if ($signed(lane_ext[k]) > $signed(acc_nxt)) acc_nxt = lane_ext[k];
               default: acc_nxt = acc_nxt;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mode_r     <= '0;
         m_r        <= '0;
         s_r        <= '0;
         row        <= '0;
         tok        <= '0;
         acc        <= '0;
         checksum   <= '0;
         in_ready   <= 1'b0;
         row_valid  <= 1'b0;
         row_idx    <= '0;
         row_result <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  checksum <= '0;
                  mode_r   <= mode;
                  m_r      <= m_rows;
                  s_r      <= s_tokens;
                  row      <= '0;
                  tok      <= '0;
                  if (mode == 2'd3 || m_rows == '0 || s_tokens == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state    <= RUN;
                     busy     <= 1'b1;
                     in_ready <= (mode != M_INDEX);
                     acc      <= acc_init(mode);
                  end
               end
            end
            RUN: begin
               if (beat_go) begin
                  if (last_beat) begin
                     row_result <= acc_nxt;
                     row_idx    <= row[DIM_W-1:0];
                     row_valid  <= 1'b1;
                     in_ready   <= 1'b0;
                     state      <= ROW_OUT;
                  end else begin
                     acc <= acc_nxt;
                     tok <= tok + TW'(LANES);
                  end
               end
            end
            ROW_OUT: begin
               if (row_ready) begin
                  row_valid <= 1'b0;
                  checksum  <= checksum + row_result;
                  if (last_row) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     row      <= row + 1'b1;
                     tok      <= '0;
                     acc      <= acc_init(mode_r);
                     in_ready <= (mode_r != M_INDEX);
                     state    <= RUN;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
